// File: rtl/fracbnn_layer_sequencer.sv
// fracbnn_layer_sequencer: steps the FracBNN core through a multi-layer job; watchdog enabled by FRACBNN_SEQ_TIMEOUT_EN
module fracbnn_layer_sequencer #(
    parameter int LAYER_W = 4,
    parameter int ADDR_W = 32
`ifdef FRACBNN_SEQ_TIMEOUT_EN
    ,
    parameter int TIMEOUT_W = 20
`endif
) (
    input  logic               ACLK,
    input  logic               ARESET,
    input  logic               start,
    input  logic               abort,
    input  logic               clr_status,
    input  logic [LAYER_W-1:0] num_layers,
    input  logic [ADDR_W-1:0]  base_addr,
    input  logic [ADDR_W-1:0]  layer_stride,
    output logic               core_start,
    output logic [LAYER_W-1:0] core_layer,
    output logic [ADDR_W-1:0]  core_addr,
    input  logic               core_done,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic               irq
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
    state_t state, state_n;
    logic [LAYER_W-1:0] count;
    logic [ADDR_W-1:0] stride;
    logic load, zero_err, adv, fin, tmo, last, done_n, err_n;
    assign last = core_layer == count - LAYER_W'(1);
`ifdef FRACBNN_SEQ_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] wd;
    assign tmo = state == WAIT && !abort && !core_done && wd == {{(TIMEOUT_W-1){1'b1}}, 1'b0};
    // watchdog restarts on every issue and counts cycles spent waiting for the core
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) wd <= '0;
        else if (state == ISSUE) wd <= '0;
        else if (state == WAIT) wd <= wd + TIMEOUT_W'(1);
    end
`else
    assign tmo = 1'b0;
`endif
    // next state and sticky status; abort dominates completion and timeout
    always_comb begin
        state_n = state;
        load = 1'b0;
        zero_err = 1'b0;
        adv = 1'b0;
        fin = 1'b0;
        case (state)
            IDLE: begin
                load = start && num_layers != '0;
                zero_err = start && num_layers == '0;
                state_n = load ? ISSUE : IDLE;
            end
            ISSUE: state_n = abort ? IDLE : WAIT;
            WAIT: begin
                fin = !abort && core_done && last;
                adv = !abort && core_done && !last;
                state_n = (abort || fin || tmo) ? IDLE : adv ? ISSUE : WAIT;
            end
            default: state_n = IDLE;
        endcase
        done_n = fin | (done & ~(load | zero_err | clr_status));
        err_n = zero_err | tmo | (err & ~(load | clr_status));
    end
    // state register with all status outputs registered from their next values
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state <= IDLE;
            busy <= 1'b0;
            core_start <= 1'b0;
            done <= 1'b0;
            err <= 1'b0;
            irq <= 1'b0;
        end else begin
            state <= state_n;
            busy <= state_n != IDLE;
            core_start <= state_n == ISSUE;
            done <= done_n;
            err <= err_n;
            irq <= done_n | err_n;
        end
    end
    // job configuration latch and per-layer index/address advance
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            count <= '0;
            stride <= '0;
            core_layer <= '0;
            core_addr <= '0;
        end else if (load) begin
            count <= num_layers;
            stride <= layer_stride;
            core_layer <= '0;
            core_addr <= base_addr;
        end else if (adv) begin
            core_layer <= core_layer + LAYER_W'(1);
            core_addr <= core_addr + stride;
        end
    end
endmodule
